// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage RV32I pipeline.
// Owns the fetch PC, addresses the combinational instruction memory and
// loads the IF/ID pipeline register for decode.
//
// Control inputs are level-sampled on each rising edge. Priority is
// redirect > (stall & flush) > stall > flush > normal fetch. There is no
// valid/ready handshake here; stall is the only back-pressure.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  im_addr,
  input  logic [31:0] im_dout,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc_plus4;
  logic [31:0] pc_d;
  logic [31:0] if_id_pc_d;
  logic [31:0] if_id_pc4_d;
  logic [31:0] if_id_inst_d;
  logic        if_id_valid_d;
  logic        misalign_err_d;
  logic [31:0] fetch_cnt_d;

  // Word address straight from the PC register; fetch aliases every 512 bytes.
  assign im_addr  = pc[8:2];
  assign pc_plus4 = pc + 32'd4;

  // Next-state selection in priority order; defaults hold everything.
  always_comb begin
    pc_d           = pc;
    if_id_pc_d     = if_id_pc;
    if_id_pc4_d    = if_id_pc4;
    if_id_inst_d   = if_id_inst;
    if_id_valid_d  = if_id_valid;
    misalign_err_d = misalign_err;
    fetch_cnt_d    = fetch_cnt;

    if (redirect) begin
      // Target low bits are dropped so pc[1:0] stays zero; the error is sticky.
      pc_d          = {redirect_pc[31:2], 2'b00};
      if_id_pc_d    = 32'd0;
      if_id_pc4_d   = 32'd0;
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err_d = 1'b1;
      end
    end else if (stall && flush) begin
      if_id_pc_d    = 32'd0;
      if_id_pc4_d   = 32'd0;
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
    end else if (stall) begin
      // Hold PC and IF/ID; defaults already cover this.
      pc_d = pc;
    end else if (flush) begin
      pc_d          = pc_plus4;
      if_id_pc_d    = 32'd0;
      if_id_pc4_d   = 32'd0;
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
    end else begin
      pc_d          = pc_plus4;
      if_id_pc_d    = pc;
      if_id_pc4_d   = pc_plus4;
      if_id_inst_d  = im_dout;
      if_id_valid_d = 1'b1;
      if (fetch_cnt != 32'hFFFF_FFFF) begin
        fetch_cnt_d = fetch_cnt + 32'd1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      if_id_pc     <= 32'd0;
      if_id_pc4    <= 32'd0;
      if_id_inst   <= NOP_INST;
      if_id_valid  <= 1'b0;
      misalign_err <= 1'b0;
      fetch_cnt    <= 32'd0;
    end else begin
      pc           <= pc_d;
      if_id_pc     <= if_id_pc_d;
      if_id_pc4    <= if_id_pc4_d;
      if_id_inst   <= if_id_inst_d;
      if_id_valid  <= if_id_valid_d;
      misalign_err <= misalign_err_d;
      fetch_cnt    <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with hand-computed expected values.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [6:0]  im_addr;
  logic [31:0] im_dout;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  logic [31:0] mem [128];

  int n_vec;
  int n_err;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .im_addr      (im_addr),
    .im_dout      (im_dout),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .pc           (pc),
    .if_id_pc     (if_id_pc),
    .if_id_pc4    (if_id_pc4),
    .if_id_inst   (if_id_inst),
    .if_id_valid  (if_id_valid),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt)
  );

  // Combinational instruction memory model.
  assign im_dout = mem[im_addr];

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] rp, input logic s, input logic f);
    redirect    = r;
    redirect_pc = rp;
    stall       = s;
    flush       = f;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},    pc, 32'h0);
    check({tag, "_addr"},  {25'd0, im_addr}, 32'h0);
    check({tag, "_idpc"},  if_id_pc, 32'h0);
    check({tag, "_idpc4"}, if_id_pc4, 32'h0);
    check({tag, "_inst"},  if_id_inst, 32'h13);
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'h0);
    check({tag, "_err"},   {31'd0, misalign_err}, 32'h0);
    check({tag, "_cnt"},   fetch_cnt, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | i;
    mem[0]  = 32'h1234_5037;
    mem[1]  = 32'h00A0_0113;
    mem[2]  = 32'h0140_0193;
    mem[38] = 32'h0000_006F;

    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    check_reset("rst");
    rst = 1'b0;

    // Sequential fetch.
    step();
    check("e1_inst",  if_id_inst, 32'h1234_5037);
    check("e1_idpc",  if_id_pc, 32'h0);
    check("e1_idpc4", if_id_pc4, 32'h4);
    check("e1_valid", {31'd0, if_id_valid}, 32'h1);
    check("e1_pc",    pc, 32'h4);
    check("e1_cnt",   fetch_cnt, 32'h1);
    step();
    check("e2_pc",    pc, 32'h8);
    check("e2_inst",  if_id_inst, 32'h00A0_0113);

    // Stall two cycles at pc=8.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("st_pc",    pc, 32'h8);
      check("st_idpc",  if_id_pc, 32'h4);
      check("st_inst",  if_id_inst, 32'h00A0_0113);
      check("st_cnt",   fetch_cnt, 32'h2);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("e3_inst",  if_id_inst, 32'h0140_0193);
    check("e3_idpc",  if_id_pc, 32'h8);
    check("e3_pc",    pc, 32'hC);
    check("e3_cnt",   fetch_cnt, 32'h3);
    step();
    check("e4_pc",    pc, 32'h10);
    check("e4_inst",  if_id_inst, 32'hA000_0003);

    // Redirect with stall on the same edge.
    drive(1'b1, 32'h98, 1'b1, 1'b0);
    step();
    check("rd_pc",    pc, 32'h98);
    check("rd_valid", {31'd0, if_id_valid}, 32'h0);
    check("rd_inst",  if_id_inst, 32'h13);
    check("rd_idpc",  if_id_pc, 32'h0);
    check("rd_idpc4", if_id_pc4, 32'h0);
    check("rd_cnt",   fetch_cnt, 32'h4);
    check("rd_err",   {31'd0, misalign_err}, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("rd2_idpc",  if_id_pc, 32'h98);
    check("rd2_idpc4", if_id_pc4, 32'h9C);
    check("rd2_inst",  if_id_inst, 32'h0000_006F);
    check("rd2_pc",    pc, 32'h9C);
    check("rd2_cnt",   fetch_cnt, 32'h5);

    // Flush only at pc=0x20.
    drive(1'b1, 32'h20, 1'b0, 1'b0);
    step();
    check("fl0_pc",   pc, 32'h20);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    step();
    check("fl_pc",    pc, 32'h24);
    check("fl_valid", {31'd0, if_id_valid}, 32'h0);
    check("fl_cnt",   fetch_cnt, 32'h5);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("n_idpc",   if_id_pc, 32'h24);
    check("n_inst",   if_id_inst, 32'hA000_0009);
    check("n_cnt",    fetch_cnt, 32'h6);

    // Stall and flush together: PC holds, IF/ID bubbles.
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    step();
    check("sf_pc",    pc, 32'h28);
    check("sf_valid", {31'd0, if_id_valid}, 32'h0);
    check("sf_inst",  if_id_inst, 32'h13);
    check("sf_idpc",  if_id_pc, 32'h0);
    check("sf_cnt",   fetch_cnt, 32'h6);

    // Misaligned redirect target.
    drive(1'b1, 32'h46, 1'b0, 1'b0);
    step();
    check("ma_pc",    pc, 32'h44);
    check("ma_err",   {31'd0, misalign_err}, 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    check("ma_err10", {31'd0, misalign_err}, 32'h1);
    check("ma_pc10",  pc, 32'h6C);
    check("ma_cnt10", fetch_cnt, 32'h10);
    #2 rst = 1'b1;
    #1;
    check_reset("ma_rst");
    #1 rst = 1'b0;

    // Fetch address aliasing at 0x200.
    drive(1'b1, 32'h1FC, 1'b0, 1'b0);
    step();
    check("al_pc",    pc, 32'h1FC);
    check("al_addr",  {25'd0, im_addr}, 32'h7F);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("al2_pc",   pc, 32'h200);
    check("al2_addr", {25'd0, im_addr}, 32'h0);
    check("al2_inst", if_id_inst, 32'hA000_007F);
    check("al2_cnt",  fetch_cnt, 32'h1);
    step();
    check("al3_inst", if_id_inst, 32'h1234_5037);
    check("al3_idpc", if_id_pc, 32'h200);

    // 32-bit PC wrap.
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step();
    check("wr_pc",    pc, 32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("wr2_pc",    pc, 32'h0);
    check("wr2_idpc",  if_id_pc, 32'hFFFF_FFFC);
    check("wr2_idpc4", if_id_pc4, 32'h0);
    check("wr2_inst",  if_id_inst, 32'hA000_007F);

    // Async reset between edges while redirect and stall are asserted.
    drive(1'b1, 32'h1FC, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_reset("ar");
    step();
    check_reset("ar_hold");
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
